alu_dispatch_rob: RTL
=====================

Name: alu_dispatch_rob

Overview:
- Parametrised, pipelined successor to the combinational 64-bit ALU class mux.
- Accepts operations over a valid/ready handshake and decodes the unit class from the opcode MSBs.
- Issues each operation, with a tag, to one of NUM_UNITS external execution units (int/fpu/vector/crypto at default).
- Collects out-of-order unit responses in a DEPTH-entry reorder buffer and returns results strictly in issue order. Supports flush with epoch-based discard of stale responses.

Parameters:
- XLEN, 64, operand/result width.
- OPC_W, 5, opcode width.
- CLS_W, 2, number of opcode MSBs selecting the unit; NUM_UNITS = 2**CLS_W (localparam).
- DEPTH, 8, reorder buffer entries; power of two, >= 2; TAG_W = $clog2(DEPTH) (localparam).

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  synchronous active-low reset
- flush  in  1  synchronous flush of all in-flight entries
- in_valid  in  1  operation request
- in_ready  out  1  operation accepted when in_valid & in_ready
- in_a  in  XLEN  operand A
- in_b  in  XLEN  operand B
- in_opcode  in  OPC_W  opcode; class = in_opcode[OPC_W-1 -: CLS_W]
- u_req_valid  out  NUM_UNITS  one-hot issue strobe per unit
- u_req_ready  in  NUM_UNITS  per-unit ready
- u_req_a, u_req_b  out  XLEN each  broadcast operands (= in_a, in_b)
- u_req_opcode  out  OPC_W  broadcast opcode
- u_req_tag  out  TAG_W+1  {epoch, tail index}
- u_resp_valid  in  NUM_UNITS  per-unit response strobe
- u_resp_tag  in  NUM_UNITS*(TAG_W+1)  unit i in slice i
- u_resp_data  in  NUM_UNITS*XLEN  unit i result in slice i
- u_resp_err  in  NUM_UNITS  unit reports unsupported op (inverse of unit valid)
- out_valid  out  1  head result available
- out_ready  in  1  consumer ready
- out_result  out  XLEN  head result
- out_err  out  1  head result flagged illegal by unit
- occupancy  out  TAG_W+1  entries in flight (0..DEPTH)
- spurious_resp  out  1  sticky: response hit a non-busy or already-done entry

Behaviour:
- Reset (rst_n=0 at clk edge): head=tail=0, count=0, epoch=0, all busy/done bits 0, spurious_resp=0.
  - Outputs after reset: out_valid=0, out_result=0, out_err=0, occupancy=0, in_ready=1 if the selected unit is ready.
  - Units share rst_n; reset mid-operation abandons all entries silently.
- Issue is combinational:
  - u_req_valid[c] = in_valid & (count<DEPTH) & !flush & (cls==c); in_ready = (count<DEPTH) & !flush & u_req_ready[cls].
  - Full is evaluated on the registered count; a retire in the same cycle does not free a slot for issue.
- On accept: entry[tail].busy=1, done=0; tag = {epoch, tail}; tail++ (wraps mod DEPTH).
- Response capture: for each unit i with u_resp_valid[i]:
  - Condition: tag epoch == current epoch, entry busy, and not done.
  - Action: write data and err, set done.
  - Multiple units may write distinct entries in one cycle; all captured.
  - Epoch mismatch: drop silently.
  - Epoch match but entry not busy or already done: drop and set spurious_resp (sticky until reset).
  - Two units responding with the same tag in one cycle: lowest index wins; the others set spurious_resp.
- Retire:
  - out_valid = busy[head] & done[head]; out_result/out_err read entry[head] (zero when !out_valid).
  - On out_valid & out_ready: busy[head]=0, head++.
  - Payload is held stable while out_valid & !out_ready.
- count updates +accept -retire; simultaneous accept and retire leaves count unchanged; occupancy = count.
- Minimum latency: accept at cycle t, unit responds at t+1, out_valid at t+2.
  - A response in the same cycle as its request is legal, giving out_valid at t+1.
- Flush (flush=1 at clk edge):
  - Clears all busy/done bits, head=tail=count=0, toggles epoch; in_ready=0 during flush.
  - A retire coinciding with flush is discarded.
  - Responses carrying the old epoch arriving later are dropped without setting spurious_resp.
- Wrap-around: indices wrap at DEPTH; epoch is independent of wrap (it changes only on flush).

Test Plan:
1. Reset then single op: opcode=5'b00010, a=5, b=7; int unit (0) returns 12 with tag 0 one cycle later -> out_valid two cycles after accept, out_result=12, out_err=0, occupancy 1->0 on retire.
2. Out-of-order completion: issue tags 0(unit 1), 1(unit 0), 2(unit 3); responses arrive in order 2, 1, 0 -> outputs appear in order tag 0, 1, 2; out_valid stays 0 until tag 0 is done.
3. Full/backpressure: DEPTH=8, out_ready=0, 8 accepts -> occupancy=8, in_ready=0. A 9th in_valid is not issued (u_req_valid=0). Asserting out_ready with in_valid the same cycle -> retire only; accept on the next cycle.
4. Unit stall: u_req_ready[2]=0 with a class-2 op -> in_ready=0, no tail advance; release -> accepted with tag {0,tail}.
5. Flush: 3 ops in flight, flush pulse -> occupancy=0, epoch=1. Late responses with epoch 0 -> no out_valid and spurious_resp=0. New op gets tag {1,0}.
6. Error and spurious cases: unit 3 returns err=1 -> out_err=1 with its result. A duplicate response to an already-done tag, and a response to an idle tag with the current epoch -> spurious_resp=1 and held.

Source files
------------

// File: rtl/alu_dispatch_rob.sv
// -----------------------------------------------------------------------------
// alu_dispatch_rob
//
// Pipelined dispatcher for the ALU unit classes. An operation is accepted over
// a valid/ready handshake. It is issued with a tag to the external execution
// unit chosen by the opcode MSBs. Out-of-order unit responses are collected in
// a DEPTH-entry reorder buffer. Results are handed back strictly in issue order.
// A flush discards everything in flight and toggles the epoch bit carried in
// every tag, so that late responses from before the flush can be recognised
// and dropped.
//
// Ports:
//   clk, rst_n          clock (rising edge), synchronous active-low reset
//   flush               synchronous flush of all in-flight entries
//   in_valid/in_ready   operation handshake; in_a, in_b, in_opcode payload
//   u_req_valid         one-hot issue strobe per unit; u_req_ready per unit
//   u_req_a/b/opcode    broadcast operands and opcode
//   u_req_tag           {epoch, tail index} of the issued operation
//   u_resp_valid/tag/data/err  per-unit response, unit i in slice i
//   out_valid/out_ready in-order result handshake; out_result, out_err payload
//   occupancy           entries in flight (0..DEPTH)
//   spurious_resp       sticky flag: a current-epoch response hit an entry
//                       that was idle or already complete
// -----------------------------------------------------------------------------
module alu_dispatch_rob #(
   parameter  int XLEN      = 64,
   parameter  int OPC_W     = 5,
   parameter  int CLS_W     = 2,
   parameter  int DEPTH     = 8,
   localparam int NUM_UNITS = 2 ** CLS_W,
   localparam int TAG_W     = $clog2(DEPTH)
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           flush,
   input  logic                           in_valid,
   output logic                           in_ready,
   input  logic [XLEN-1:0]                in_a,
   input  logic [XLEN-1:0]                in_b,
   input  logic [OPC_W-1:0]               in_opcode,
   output logic [NUM_UNITS-1:0]           u_req_valid,
   input  logic [NUM_UNITS-1:0]           u_req_ready,
   output logic [XLEN-1:0]                u_req_a,
   output logic [XLEN-1:0]                u_req_b,
   output logic [OPC_W-1:0]               u_req_opcode,
   output logic [TAG_W:0]                 u_req_tag,
   input  logic [NUM_UNITS-1:0]           u_resp_valid,
   input  logic [NUM_UNITS*(TAG_W+1)-1:0] u_resp_tag,
   input  logic [NUM_UNITS*XLEN-1:0]      u_resp_data,
   input  logic [NUM_UNITS-1:0]           u_resp_err,
   output logic                           out_valid,
   input  logic                           out_ready,
   output logic [XLEN-1:0]                out_result,
   output logic                           out_err,
   output logic [TAG_W:0]                 occupancy,
   output logic                           spurious_resp
);

   localparam logic [TAG_W:0] FULL_CNT = (TAG_W+1)'(DEPTH);

   // Ring pointers, fill count and the epoch carried in every issued tag.
   logic [TAG_W-1:0] head;
   logic [TAG_W-1:0] tail;
   logic [TAG_W:0]   count;
   logic             epoch;
   logic             spurious_q;

   // Per-entry status and payload.
   logic [DEPTH-1:0] busy;
   logic [DEPTH-1:0] done;
   logic [XLEN-1:0]  data_q [DEPTH];
   logic [DEPTH-1:0] err_q;

   logic [CLS_W-1:0] cls;
   logic             issue_ok;
   logic             accept;
   logic             retire;
   logic [DEPTH-1:0] acc_vec;
   logic [DEPTH-1:0] ret_vec;
   logic [DEPTH-1:0] eff_busy;
   logic [DEPTH-1:0] eff_done;

   // Response capture decode.
   logic [DEPTH-1:0] cap_we;
   logic [CLS_W-1:0] cap_src [DEPTH];
   logic             spur_hit;
   logic [TAG_W:0]   r_tag;
   logic [TAG_W-1:0] r_idx;

   // ---------------------------------------------------------------------------
   // Issue. Fullness is judged on the registered count only, so a retire in
   // the same cycle never opens a slot for an accept.
   // ---------------------------------------------------------------------------
   assign cls      = in_opcode[OPC_W-1 -: CLS_W];
   assign issue_ok = (count != FULL_CNT) && !flush;
   assign in_ready = issue_ok && u_req_ready[cls];
   assign accept   = in_valid && in_ready;

   // NOTE: every signal driven from always_comb gets a default on entry, so no
   // path through the block leaves it holding a value (which would be a latch).
   always_comb begin
      u_req_valid = '0;
      if (in_valid && issue_ok) begin
         u_req_valid[cls] = 1'b1;
      end
   end

   assign u_req_a      = in_a;
   assign u_req_b      = in_b;
   assign u_req_opcode = in_opcode;
   assign u_req_tag    = {epoch, tail};

   // ---------------------------------------------------------------------------
   // Retire from the head entry.
   // ---------------------------------------------------------------------------
   assign out_valid     = busy[head] && done[head];
   assign out_result    = out_valid ? data_q[head] : '0;
   assign out_err       = out_valid && err_q[head];
   assign retire        = out_valid && out_ready;
   assign occupancy     = count;
   assign spurious_resp = spurious_q;

   assign acc_vec = accept ? (DEPTH'(1) << tail) : '0;
   assign ret_vec = retire ? (DEPTH'(1) << head) : '0;

   // The entry being accepted this cycle already counts as busy and not done.
   // A unit may therefore answer in the same cycle it receives the request.
   assign eff_busy = busy | acc_vec;
   assign eff_done = done & ~acc_vec;

   // ---------------------------------------------------------------------------
   // Response capture. Units are scanned in ascending order, so when two units
   // hit the same entry the lowest index claims it and the rest count as
   // spurious. Stale-epoch responses are ignored without comment.
   // ---------------------------------------------------------------------------
   always_comb begin
      cap_we   = '0;
      spur_hit = 1'b0;
      r_tag    = '0;
      r_idx    = '0;
      for (int j = 0; j < DEPTH; j++) begin
         cap_src[j] = '0;
      end
      for (int i = 0; i < NUM_UNITS; i++) begin
         if (u_resp_valid[i]) begin
            r_tag = u_resp_tag[i*(TAG_W+1) +: (TAG_W+1)];
            r_idx = r_tag[TAG_W-1:0];
            if (r_tag[TAG_W] == epoch) begin
               if (eff_busy[r_idx] && !eff_done[r_idx] && !cap_we[r_idx]) begin
                  cap_we[r_idx]  = 1'b1;
                  cap_src[r_idx] = CLS_W'(i);
               end else begin
                  spur_hit = 1'b1;
               end
            end
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Control state.
   // ---------------------------------------------------------------------------
   // NOTE: sequential state is updated with non-blocking assignments only, so
   // every register here samples the values from before this clock edge.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         head       <= '0;
         tail       <= '0;
         count      <= '0;
         epoch      <= 1'b0;
         busy       <= '0;
         done       <= '0;
         spurious_q <= 1'b0;
      end else begin
         if (spur_hit) begin
            spurious_q <= 1'b1;
         end
         if (flush) begin
            // A flush overrides any accept, retire or capture in the same cycle.
            head  <= '0;
            tail  <= '0;
            count <= '0;
            epoch <= ~epoch;
            busy  <= '0;
            done  <= '0;
         end else begin
            if (accept) begin
               tail <= tail + 1'b1;
            end
            if (retire) begin
               head <= head + 1'b1;
            end
            case ({accept, retire})
               2'b10:   count <= count + 1'b1;
               2'b01:   count <= count - 1'b1;
               default: count <= count;
            endcase
            busy <= (busy | acc_vec) & ~ret_vec;
            done <= (done & ~acc_vec) | cap_we;
         end
      end
   end

   // NOTE: the payload array is deliberately left out of reset. An entry's data
   // is only ever read once its done bit, which is reset, has been set by a
   // capture.
   always_ff @(posedge clk) begin
      for (int j = 0; j < DEPTH; j++) begin
         if (cap_we[j]) begin
            data_q[j] <= u_resp_data[cap_src[j]*XLEN +: XLEN];
            err_q[j]  <= u_resp_err[cap_src[j]];
         end
      end
   end

endmodule
